// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and types for the 1-to-8 buffered demux
package demux_pkg;
  localparam int N_CH    = 8;
  localparam int SEL_W   = 3;
  localparam int STALL_W = 16;

  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/demux_chan_buf.sv
// rtl/demux_chan_buf.sv - one-entry holding register with full flag for one demux channel
module demux_chan_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         ack,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);
  logic full;

  // A load wins over an ack so a same-cycle consume-and-refill keeps the channel full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full <= 1'b0;
      q    <= '0;
    end else if (load) begin
      full <= 1'b1;
      q    <= d;
    end else if (ack && full) begin
      full <= 1'b0;
    end
  end

  assign valid = full;
endmodule

// File: rtl/demux1to8_buf.sv
// rtl/demux1to8_buf.sv - registered 1-to-8 demux with per-channel holding registers
// Optional stall counter enabled by DEMUX1TO8_STALL_CNT_EN.
module demux1to8_buf
  import demux_pkg::*;
#(
  parameter int W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  sel_t            select,
  input  logic [W-1:0]    in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [W-1:0]    out_data_0,
  output logic [W-1:0]    out_data_1,
  output logic [W-1:0]    out_data_2,
  output logic [W-1:0]    out_data_3,
  output logic [W-1:0]    out_data_4,
  output logic [W-1:0]    out_data_5,
  output logic [W-1:0]    out_data_6,
  output logic [W-1:0]    out_data_7,
  output logic [N_CH-1:0] out_valid,
  input  logic [N_CH-1:0] out_ack
`ifdef DEMUX1TO8_STALL_CNT_EN
  ,
  output logic [STALL_W-1:0] stall_count
`endif
);
  logic [N_CH-1:0] full;
  logic [N_CH-1:0] load;
  logic [W-1:0]    q [N_CH];

  // An ack on the selected channel frees it in time for this cycle's write.
  assign in_ready = rst_n & (~full[select] | out_ack[select]);

  always_comb begin
    load = '0;
    if (in_valid && in_ready) load[select] = 1'b1;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    demux_chan_buf #(.W(W)) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[i]),
      .ack   (out_ack[i]),
      .d     (in_data),
      .valid (full[i]),
      .q     (q[i])
    );
  end

  assign out_valid  = full;
  assign out_data_0 = q[0];
  assign out_data_1 = q[1];
  assign out_data_2 = q[2];
  assign out_data_3 = q[3];
  assign out_data_4 = q[4];
  assign out_data_5 = q[5];
  assign out_data_6 = q[6];
  assign out_data_7 = q[7];

`ifdef DEMUX1TO8_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (in_valid && !in_ready && (stall_count != {STALL_W{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end
`endif

  // Producer must hold select and data steady while a word is waiting.
  a_producer_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (in_valid && !in_ready) |=> (!in_valid || ($stable(select) && $stable(in_data))));
endmodule

// File: tb/tb_demux1to8_buf.sv
// tb/tb_demux1to8_buf.sv - directed table-driven bench for demux1to8_buf
module tb_demux1to8_buf;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] select;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data_0, out_data_1, out_data_2, out_data_3;
  logic [7:0] out_data_4, out_data_5, out_data_6, out_data_7;
  logic [7:0] out_valid;
  logic [7:0] out_ack;
`ifdef DEMUX1TO8_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  demux1to8_buf #(.W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .select     (select),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data_0 (out_data_0),
    .out_data_1 (out_data_1),
    .out_data_2 (out_data_2),
    .out_data_3 (out_data_3),
    .out_data_4 (out_data_4),
    .out_data_5 (out_data_5),
    .out_data_6 (out_data_6),
    .out_data_7 (out_data_7),
    .out_valid  (out_valid),
    .out_ack    (out_ack)
`ifdef DEMUX1TO8_STALL_CNT_EN
    ,
    .stall_count(stall_count)
`endif
  );

  logic [7:0] od [8];
  assign od[0] = out_data_0;
  assign od[1] = out_data_1;
  assign od[2] = out_data_2;
  assign od[3] = out_data_3;
  assign od[4] = out_data_4;
  assign od[5] = out_data_5;
  assign od[6] = out_data_6;
  assign od[7] = out_data_7;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] data;
    logic [7:0] ack;
    logic       exp_ready;
    logic [7:0] exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      vecs[i].sel       = 3'(i);
      vecs[i].data      = 8'hA0 + 8'(i);
      vecs[i].ack       = 8'h00;
      vecs[i].exp_ready = 1'b1;
      vecs[i].exp_valid = 8'((16'h1 << (i + 1)) - 1);
      vecs[i].exp_data  = 8'hA0 + 8'(i);
    end

    // reset with a pending word
    rst_n = 1'b0; in_valid = 1'b1; select = 3'd0; in_data = 8'hFF; out_ack = 8'h00;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    step();
    step();
    chk("rst_in_ready2", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    for (int i = 0; i < 8; i++) chk($sformatf("rst_data%0d", i), 32'(od[i]), 32'h0);
`ifdef DEMUX1TO8_STALL_CNT_EN
    chk("rst_stall", 32'(stall_count), 32'h0);
`endif

    // routing table
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      select = vecs[i].sel; in_data = vecs[i].data; out_ack = vecs[i].ack; in_valid = 1'b1;
      #1;
      chk($sformatf("route_ready%0d", i), 32'(in_ready), 32'(vecs[i].exp_ready));
      step();
      chk($sformatf("route_valid%0d", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("route_data%0d", i), 32'(od[vecs[i].sel]), 32'(vecs[i].exp_data));
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) chk($sformatf("route_hold%0d", i), 32'(od[i]), 32'(8'hA0 + 8'(i)));

    // backpressure on full channel 3
    select = 3'd3; in_data = 8'h77; in_valid = 1'b1;
    #1;
    chk("bp_ready", 32'(in_ready), 32'h0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("bp_ready_hold", 32'(in_ready), 32'h0);
      chk("bp_data3", 32'(out_data_3), 32'hA3);
    end
`ifdef DEMUX1TO8_STALL_CNT_EN
    chk("bp_stall4", 32'(stall_count), 32'h4);
`endif
    in_valid = 1'b0;

    // simultaneous ack and write on channel 5
    out_ack = 8'h20;
    step();
    chk("ack5_free", 32'(out_valid), 32'hDF);
    out_ack = 8'h00; select = 3'd5; in_data = 8'h11; in_valid = 1'b1;
    #1;
    chk("w11_ready", 32'(in_ready), 32'h1);
    step();
    chk("w11_data", 32'(out_data_5), 32'h11);
    out_ack = 8'h20; in_data = 8'h22;
    #1;
    chk("ackw_ready", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0; out_ack = 8'h00;
    chk("ackw_data5", 32'(out_data_5), 32'h22);
    chk("ackw_valid", 32'(out_valid), 32'hFF);
`ifdef DEMUX1TO8_STALL_CNT_EN
    chk("stall_still4", 32'(stall_count), 32'h4);
`endif

    // multi-ack and stray ack on empty channel 1
    out_ack = 8'h7E;
    step();
    chk("leave_0_7", 32'(out_valid), 32'h81);
    out_ack = 8'h83;
    step();
    out_ack = 8'h00;
    chk("multiack_valid", 32'(out_valid), 32'h00);
    chk("stray_data1", 32'(out_data_1), 32'hA1);
    chk("acked_data0", 32'(out_data_0), 32'hA0);

    // reset mid-stream
    select = 3'd2; in_data = 8'h33; in_valid = 1'b1;
    step();
    select = 3'd6; in_data = 8'h66;
    step();
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'h44);
    rst_n = 1'b0; select = 3'd2; in_data = 8'h5A; in_valid = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(in_ready), 32'h0);
    step();
    chk("mid_rst_valid", 32'(out_valid), 32'h00);
    chk("mid_rst_data2", 32'(out_data_2), 32'h00);
`ifdef DEMUX1TO8_STALL_CNT_EN
    chk("mid_rst_stall", 32'(stall_count), 32'h0);
`endif
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    chk("post_rst_data2", 32'(out_data_2), 32'h5A);
    chk("post_rst_valid", 32'(out_valid), 32'h04);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/demux1to8_buf.md
# demux1to8_buf

- Registered 1-to-8 demultiplexer with one holding register per output channel and a valid/ready handshake.
- Routes each accepted `in_data` word to the channel chosen by `select`, holding it there until that channel's consumer acknowledges it.
- Sits on the write side of the datapath as the counterpart of the 8-to-1 select mux: one producer fans out to eight consumers, such as register-bank or unit write ports.

## Interface
- `W`, default 8, data width of the input and of each channel.
- `clk` input 1, single clock; all state updates on the rising edge.
- `rst_n` input 1, synchronous active-low reset, sampled on the `clk` rising edge.
- `select` input 3, destination channel of the current input word.
- `in_data` input W, word to route.
- `in_valid` input 1, producer has a word.
- `in_ready` output 1, combinational; word is accepted this cycle when `in_valid & in_ready`.
- `out_data_0` .. `out_data_7` output W each, channel holding registers.
- `out_valid` output 8, bit i is high while channel i holds an unconsumed word.
- `out_ack` input 8, bit i is the consumer of channel i taking the word this cycle.
- `stall_count` output 16, present only with `DEMUX1TO8_STALL_CNT_EN`.

## Operation
- Per-channel state: `full[i]` and `data[i]`.
  - `out_valid[i] = full[i]`.
  - `out_data_i = data[i]`.
- `in_ready = rst_n & (~full[select] | out_ack[select])`.
  - Combinational in `select`, `full` and `out_ack`.
  - A channel freed by an ack in the same cycle accepts a new word in that cycle.
- Accept (`in_valid & in_ready`) with `select == i`:
  - `data[i] <= in_data`.
  - `full[i] <= 1`.
- No accept for channel i and `out_ack[i] & full[i]`: `full[i] <= 0`.
  - `data[i]` keeps its old value.
- `out_ack[i]` while `full[i] == 0` is ignored.
- Ack and accept on the same channel in the same cycle:
  - Old word is consumed.
  - New word is loaded.
  - `full[i]` stays 1.
- Acks on several channels in one cycle are all honoured independently.
- A write to channel i never disturbs any other channel.
- Producer rule (checked by assertion, not enforced): once `in_valid` is high, `select` and `in_data` stay stable until accepted.
- Full blocking: if `full[select]` is set and there is no ack, `in_ready` is 0.
  - Writes to other channels are still possible once `select` changes after the word is accepted.
  - There is no head-of-line bypass within one request.

## Timing
- Latency: word accepted at edge N is visible on `out_data_i` with `out_valid[i] = 1` immediately after edge N.
- Throughput: one word per cycle, provided the selected channel is acked every cycle.
- Reset values, taken at the first rising edge with `rst_n = 0`:
  - `full` = 0.
  - All `out_data_*` = 0.
  - `out_valid` = 0.
  - `stall_count` = 0.
- While `rst_n` is low, `in_ready` is 0, so nothing is accepted.
- Reset mid-operation:
  - All held words are discarded with no acknowledge.
  - Operation resumes at the first edge with `rst_n` high.

## Configuration
- `DEMUX1TO8_STALL_CNT_EN` defined:
  - `stall_count` port exists.
  - It increments by 1 on each edge where `in_valid & ~in_ready & rst_n`.
  - It saturates at 16'hFFFF.
  - It clears on reset.
- `DEMUX1TO8_STALL_CNT_EN` undefined:
  - The port and counter are absent.
  - Datapath behaviour is otherwise identical.

## Structure
- Shared package `demux_pkg`:
  - `N_CH = 8`.
  - `SEL_W = 3`.
  - `STALL_W = 16`.
  - `sel_t` typedef for the channel index.
- Natural sub-module `demux_chan_buf`, instantiated eight times:
  - One-entry holding register with `full` flag.
  - Inputs: `load`, `ack`, `d`.
  - Outputs: `valid`, `q`.
- Top level: decode of `select` into one-hot load enables, plus the `in_ready` mux and the optional counter.

## Test plan
- Reset: hold `rst_n = 0` for 2 cycles with `in_valid = 1` -> `in_ready = 0`, `out_valid = 8'h00`, all `out_data_*` = 0, `stall_count = 0`.
- Routing: write 8'hA0+i to `select = i` for i = 0..7 on consecutive cycles, no acks -> after 8 edges `out_valid = 8'hFF` and `out_data_i = 8'hA0+i`.
- Backpressure: channel 3 full, no ack, `in_valid = 1`, `select = 3` -> `in_ready = 0` and data unchanged; with the macro defined, `stall_count` reads 4 after 4 stalled cycles.
- Simultaneous ack and write: channel 5 holds 8'h11; assert `out_ack[5]` and write 8'h22 to channel 5 in the same cycle -> `in_ready = 1`, next cycle `out_data_5 = 8'h22`, `out_valid[5] = 1`.
- Multi-ack and stray ack: channels 0 and 7 full; `out_ack = 8'h83` -> `out_valid = 8'h00` next cycle, and channel 1 (empty) is unaffected.
- Reset mid-stream: channels 2 and 6 full; `rst_n = 0` for 1 cycle -> `out_valid = 0`, then a write to channel 2 with 8'h5A is accepted and appears one cycle later.
